// File: rtl/wb_pkg.sv
// Shared types and helpers for the multi-lane writeback stage.
// The request layout fixes data/regno widths; wb_stage_mp's DBITS/REGNOBITS must match them.
package wb_pkg;

  localparam int WB_DBITS     = 32;
  localparam int WB_REGNOBITS = 5;

  typedef struct packed {
    logic [WB_REGNOBITS-1:0] regno;
    logic [WB_DBITS-1:0]     data;
  } wb_req_t;

  // Per-register pending counters must hold 0..DEPTH.
  function automatic int wb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int wb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/wb_mq_fifo.sv
// Circular pending-write queue: up to LANES compacted pushes and up to WPORTS
// pops per cycle, exposing occupancy and the oldest WPORTS entries.
module wb_mq_fifo
  import wb_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4,
  localparam int PW = wb_ptr_w(DEPTH),
  localparam int CW = wb_cnt_w(DEPTH),
  localparam int LW = $clog2(LANES + 1),
  localparam int RW = $clog2(WPORTS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LW-1:0]            push_n,
  input  wb_req_t [LANES-1:0]      push_data,
  input  logic [RW-1:0]            pop_n,
  output logic [CW-1:0]            occ,
  output wb_req_t [WPORTS-1:0]     head_data
);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] head, tail;

  // base < DEPTH and off <= DEPTH, so a single subtract wraps correctly
  // for any DEPTH, power of two or not.
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s -= DEPTH;
    return PW'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (i < int'(push_n)) mem[wrap(tail, i)] <= push_data[i];
      tail <= wrap(tail, int'(push_n));
      head <= wrap(head, int'(pop_n));
      occ  <= CW'(int'(occ) + int'(push_n) - int'(pop_n));
    end
  end

  always_comb begin
    head_data = '0;
    for (int p = 0; p < WPORTS; p++) head_data[p] = mem[wrap(head, p)];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (int'(occ) + int'(push_n) <= DEPTH);
      assert (int'(pop_n) <= int'(occ));
    end
  end

endmodule

// File: rtl/wb_stage_mp.sv
// Multi-lane writeback: buffers register writes in order, drains them through
// WPORTS register-file ports, and tracks per-register pending writes.
module wb_stage_mp
  import wb_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int WPORTS    = 1,
  parameter int DEPTH     = 4,
  parameter int DBITS     = WB_DBITS,
  parameter int REGNOBITS = WB_REGNOBITS,
  parameter int REGWORDS  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              in_valid,
  input  logic [LANES-1:0]              in_wr_reg,
  input  logic [LANES*REGNOBITS-1:0]    in_regno,
  input  logic [LANES*DBITS-1:0]        in_data,
  output logic                          in_ready,
  output logic [WPORTS-1:0]             wr_en,
  output logic [WPORTS*REGNOBITS-1:0]   wr_regno,
  output logic [WPORTS*DBITS-1:0]       wr_data,
  output logic [REGWORDS-1:0]           pending_mask,
  output logic [63:0]                   retired_count,
  output logic                          idle
);

  localparam int CW = wb_cnt_w(DEPTH);
  localparam int LW = $clog2(LANES + 1);
  localparam int RW = $clog2(WPORTS + 1);

  logic [CW-1:0]                occ;
  logic [LW-1:0]                push_n;
  wb_req_t [LANES-1:0]          push_data;
  logic [RW-1:0]                pop_n;
  wb_req_t [WPORTS-1:0]         head_data;
  logic [WPORTS-1:0]            head_vld;
  logic [REGWORDS-1:0][CW-1:0]  cnt, cnt_nxt;
  logic                         cnt_uflow;

  // Conservative all-or-nothing admission: ignores this cycle's pops so
  // in_ready never depends on the consumer.
  assign in_ready = !reset && (int'(occ) + LANES <= DEPTH);
  assign idle     = (occ == '0);

  // Compact the writing lanes into consecutive queue slots, lane 0 first.
  always_comb begin
    push_data = '0;
    push_n    = '0;
    for (int l = 0; l < LANES; l++) begin
      if (in_ready && in_valid[l] && in_wr_reg[l] &&
          in_regno[l*REGNOBITS +: REGNOBITS] != '0) begin
        push_data[push_n] = '{regno: in_regno[l*REGNOBITS +: REGNOBITS],
                              data:  in_data[l*DBITS +: DBITS]};
        push_n = push_n + LW'(1);
      end
    end
  end

  always_comb begin
    head_vld = '0;
    for (int p = 0; p < WPORTS; p++) head_vld[p] = !reset && (p < int'(occ));
    pop_n = RW'(popcount(64'(head_vld)));
  end

  wb_mq_fifo #(
    .LANES  (LANES),
    .WPORTS (WPORTS),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .occ       (occ),
    .head_data (head_data)
  );

  // A younger port to the same register supersedes an older one; the older
  // entry is still popped.
  always_comb begin
    wr_en    = '0;
    wr_regno = '0;
    wr_data  = '0;
    for (int p = 0; p < WPORTS; p++) begin
      wr_en[p] = head_vld[p];
      for (int q = p + 1; q < WPORTS; q++)
        if (head_vld[q] && head_data[q].regno == head_data[p].regno) wr_en[p] = 1'b0;
      wr_regno[p*REGNOBITS +: REGNOBITS] = head_data[p].regno;
      wr_data[p*DBITS +: DBITS]          = head_data[p].data;
    end
  end

  // Pushes are applied before pops, so intermediate values stay within 0..DEPTH.
  always_comb begin
    cnt_nxt = cnt;
    for (int i = 0; i < LANES; i++)
      if (i < int'(push_n)) cnt_nxt[push_data[i].regno] += CW'(1);
    for (int p = 0; p < WPORTS; p++)
      if (head_vld[p]) cnt_nxt[head_data[p].regno] -= CW'(1);
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 1; r < REGWORDS; r++) pending_mask[r] = (cnt[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      retired_count <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (in_ready) retired_count <= retired_count + 64'(popcount(64'(in_valid)));
    end
  end

  always_comb begin
    cnt_uflow = 1'b0;
    for (int r = 0; r < REGWORDS; r++) begin
      int bal;
      bal = int'(cnt[r]);
      for (int i = 0; i < LANES; i++)
        if (i < int'(push_n) && int'(push_data[i].regno) == r) bal++;
      for (int p = 0; p < WPORTS; p++)
        if (head_vld[p] && int'(head_data[p].regno) == r) bal--;
      if (bal < 0) cnt_uflow = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!cnt_uflow);
  end

endmodule
